// File: rtl/core_pkg.sv
// Shared definitions for the fetch front end: FSM state encoding, default reset/trap
// vectors and instruction width. The TRAP state exists only when MISALIGN_TRAP_EN is defined.
package core_pkg;

    localparam int          INST_WIDTH       = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC_DEFAULT = 32'h0000_0100;

`ifdef MISALIGN_TRAP_EN
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_TRAP  = 2'd3
    } pc_state_t;
`else
    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } pc_state_t;
`endif

    function automatic logic [INST_WIDTH-1:0] pc_inc(input logic [INST_WIDTH-1:0] pc);
        return pc + INST_WIDTH'(4);
    endfunction

endpackage

// File: rtl/pc_controller.sv
// Program-counter / fetch-request controller with redirect, drain of stale fetches and stall.
// Optional misaligned-target trap enabled by defining MISALIGN_TRAP_EN.
module pc_controller
    import core_pkg::*;
#(
    parameter logic [INST_WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [INST_WIDTH-1:0] TRAP_VEC = TRAP_VEC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  branch_ctrl,
    input  logic                  branch_valid,
    input  logic                  jump_valid,
    input  logic [INST_WIDTH-1:0] target_addr,
    input  logic                  stall,
    output logic                  if_req,
    output logic [INST_WIDTH-1:0] if_addr,
    input  logic                  if_ack,
    output logic                  inst_valid,
    output logic [INST_WIDTH-1:0] inst_pc,
    output logic                  flush,
    output logic                  trap
);

    pc_state_t             state_reg, state_next;
    logic [INST_WIDTH-1:0] pc_reg, pc_next;
    logic [INST_WIDTH-1:0] tgt_reg, tgt_next;
    logic                  req_reg, req_next;

    logic                  redirect;
    logic [INST_WIDTH-1:0] tgt_in;

    // Redirects only matter once fetching has started; BOOT has nothing to kill.
    assign redirect = ((branch_valid & branch_ctrl) | jump_valid) &
                      ((state_reg == ST_FETCH) | (state_reg == ST_DRAIN));

`ifdef MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = |target_addr[1:0];
    assign tgt_in     = target_addr;
    assign trap       = redirect & misaligned;
`else
    logic unused_bits;
    assign unused_bits = ^{target_addr[1:0], TRAP_VEC};
    assign tgt_in      = {target_addr[INST_WIDTH-1:2], 2'b00};
    assign trap        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_BOOT;
            pc_reg    <= RESET_PC;
            tgt_reg   <= RESET_PC;
            req_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            tgt_reg   <= tgt_next;
            req_reg   <= req_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        tgt_next   = tgt_reg;
        req_next   = req_reg;
        case (state_reg)
            ST_BOOT: begin
                state_next = ST_FETCH;
                req_next   = 1'b1;
            end
            ST_FETCH: begin
                if (redirect) begin
`ifdef MISALIGN_TRAP_EN
                    if (misaligned) begin
                        state_next = ST_TRAP;
                        req_next   = req_reg & ~if_ack;
                    end else
`endif
                    if (req_reg && !if_ack) begin
                        // Request in flight: hold if_addr stable and wait for its ack.
                        state_next = ST_DRAIN;
                        tgt_next   = tgt_in;
                    end else begin
                        pc_next  = tgt_in;
                        req_next = 1'b1;
                    end
                end else if (req_reg) begin
                    if (if_ack) begin
                        pc_next  = pc_inc(pc_reg);
                        req_next = ~stall;
                    end
                end else begin
                    req_next = ~stall;
                end
            end
            ST_DRAIN: begin
                if (redirect) begin
                    tgt_next = tgt_in;
                end
`ifdef MISALIGN_TRAP_EN
                if (redirect && misaligned) begin
                    state_next = ST_TRAP;
                    req_next   = ~if_ack;
                end else
`endif
                if (if_ack) begin
                    state_next = ST_FETCH;
                    pc_next    = redirect ? tgt_in : tgt_reg;
                    req_next   = 1'b1;
                end
            end
`ifdef MISALIGN_TRAP_EN
            ST_TRAP: begin
                if (!req_reg || if_ack) begin
                    state_next = ST_FETCH;
                    pc_next    = TRAP_VEC;
                    req_next   = 1'b1;
                end
            end
`endif
            default: begin
                state_next = ST_BOOT;
                req_next   = 1'b0;
            end
        endcase
    end

    assign if_req     = req_reg;
    assign if_addr    = pc_reg;
    assign flush      = redirect;
    assign inst_valid = (state_reg == ST_FETCH) & req_reg & if_ack & ~redirect;
    assign inst_pc    = inst_valid ? pc_reg : '0;

endmodule

// File: tb/tb_pc_controller.sv
// Self-checking bench for pc_controller: per-cycle vector table run through a scoreboard
// queue, plus a hand-written reset-during-drain sequence.
module tb_pc_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        branch_ctrl, branch_valid, jump_valid, stall, if_ack;
    logic [31:0] target_addr;
    logic        if_req, inst_valid, flush, trap;
    logic [31:0] if_addr, inst_pc;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        stall, bv, bc, jv;
        logic [31:0] tgt;
        logic        ack;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid, e_flush, e_trap;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    pc_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .branch_ctrl  (branch_ctrl),
        .branch_valid (branch_valid),
        .jump_valid   (jump_valid),
        .target_addr  (target_addr),
        .stall        (stall),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_ack       (if_ack),
        .inst_valid   (inst_valid),
        .inst_pc      (inst_pc),
        .flush        (flush),
        .trap         (trap)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add_row(input logic s, input logic bv, input logic bc, input logic jv,
                                    input logic [31:0] tgt, input logic ack, input logic e_req,
                                    input logic [31:0] e_addr, input logic e_valid,
                                    input logic e_flush, input logic e_trap);
        vec_t v;
        v.stall = s; v.bv = bv; v.bc = bc; v.jv = jv; v.tgt = tgt; v.ack = ack;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_flush = e_flush; v.e_trap = e_trap;
        tbl.push_back(v);
    endfunction

    task automatic drive_idle();
        stall = 0; branch_valid = 0; branch_ctrl = 0; jump_valid = 0;
        target_addr = 32'h0; if_ack = 0;
    endtask

    initial begin
        vec_t v, e;
        logic trap_en;
`ifdef MISALIGN_TRAP_EN
        trap_en = 1'b1;
`else
        trap_en = 1'b0;
`endif
        //      stall bv bc jv target        ack | req addr          vld fl tr
        add_row(0, 0, 0, 0, 32'h0,        0,  0, 32'h0,        0, 0, 0); // BOOT
        add_row(0, 0, 0, 0, 32'h0,        1,  1, 32'h0,        1, 0, 0);
        add_row(0, 0, 0, 0, 32'h0,        1,  1, 32'h4,        1, 0, 0);
        add_row(0, 0, 0, 0, 32'h0,        1,  1, 32'h8,        1, 0, 0);
        add_row(1, 0, 0, 0, 32'h0,        1,  1, 32'hC,        1, 0, 0);
        add_row(0, 1, 1, 0, 32'h40,       0,  0, 32'h0,        0, 1, 0); // taken branch, idle
        add_row(0, 0, 0, 0, 32'h0,        0,  1, 32'h40,       0, 0, 0);
        add_row(0, 0, 0, 0, 32'h0,        1,  1, 32'h40,       1, 0, 0);
        add_row(0, 1, 0, 0, 32'h300,      0,  1, 32'h44,       0, 0, 0); // not taken
        add_row(0, 0, 0, 1, 32'h10,       1,  1, 32'h44,       0, 1, 0); // jump + same ack
        add_row(0, 0, 0, 1, 32'h80,       0,  1, 32'h10,       0, 1, 0); // enter DRAIN
        add_row(0, 0, 0, 0, 32'h0,        0,  1, 32'h10,       0, 0, 0);
        add_row(0, 0, 0, 0, 32'h0,        0,  1, 32'h10,       0, 0, 0);
        add_row(0, 0, 0, 0, 32'h0,        1,  1, 32'h10,       0, 0, 0); // stale ack
        add_row(0, 0, 0, 0, 32'h0,        1,  1, 32'h80,       1, 0, 0);
        add_row(0, 0, 0, 1, 32'h500,      0,  1, 32'h84,       0, 1, 0);
        add_row(0, 1, 1, 0, 32'h600,      0,  1, 32'h84,       0, 1, 0); // last wins
        add_row(0, 0, 0, 0, 32'h0,        1,  1, 32'h84,       0, 0, 0);
        add_row(0, 0, 0, 0, 32'h0,        1,  1, 32'h600,      1, 0, 0);
        add_row(1, 0, 0, 0, 32'h0,        1,  1, 32'h604,      1, 0, 0); // stall cycle 1
        add_row(1, 0, 0, 1, 32'h200,      0,  0, 32'h0,        0, 1, 0); // stall cycle 2
        add_row(1, 0, 0, 0, 32'h0,        0,  1, 32'h200,      0, 0, 0); // stall cycle 3
        add_row(1, 0, 0, 0, 32'h0,        1,  1, 32'h200,      1, 0, 0); // stall cycle 4
        add_row(0, 0, 0, 0, 32'h0,        0,  0, 32'h0,        0, 0, 0);
        add_row(0, 0, 0, 0, 32'h0,        1,  1, 32'h204,      1, 0, 0);
        add_row(0, 0, 0, 1, 32'h42,       1,  1, 32'h208,      0, 1, trap_en);
        if (trap_en) begin
            add_row(0, 0, 0, 0, 32'h0,    0,  0, 32'h0,        0, 0, 0);
            add_row(0, 0, 0, 0, 32'h0,    0,  1, 32'h100,      0, 0, 0);
            add_row(0, 0, 0, 1, 32'hFFFF_FFFC, 1, 1, 32'h100,  0, 1, 0);
        end else begin
            add_row(0, 0, 0, 0, 32'h0,    1,  1, 32'h40,       1, 0, 0);
            add_row(0, 0, 0, 0, 32'h0,    0,  1, 32'h44,       0, 0, 0);
            add_row(0, 0, 0, 1, 32'hFFFF_FFFC, 1, 1, 32'h44,   0, 1, 0);
        end
        add_row(0, 0, 0, 0, 32'h0,        1,  1, 32'hFFFF_FFFC, 1, 0, 0);
        add_row(0, 0, 0, 0, 32'h0,        0,  1, 32'h0,        0, 0, 0); // wrapped

        // Reset state
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset if_req", {31'b0, if_req}, 32'h0);
        chk("reset if_addr", if_addr, 32'h0);
        chk("reset inst_valid", {31'b0, inst_valid}, 32'h0);
        chk("reset inst_pc", inst_pc, 32'h0);
        chk("reset flush", {31'b0, flush}, 32'h0);
        chk("reset trap", {31'b0, trap}, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            stall = v.stall; branch_valid = v.bv; branch_ctrl = v.bc;
            jump_valid = v.jv; target_addr = v.tgt; if_ack = v.ack;
            exp_q.push_back(v);
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("row%0d if_req", i), {31'b0, if_req}, {31'b0, e.e_req});
            if (e.e_req) chk($sformatf("row%0d if_addr", i), if_addr, e.e_addr);
            chk($sformatf("row%0d inst_valid", i), {31'b0, inst_valid}, {31'b0, e.e_valid});
            chk($sformatf("row%0d inst_pc", i), inst_pc, e.e_valid ? e.e_addr : 32'h0);
            chk($sformatf("row%0d flush", i), {31'b0, flush}, {31'b0, e.e_flush});
            chk($sformatf("row%0d trap", i), {31'b0, trap}, {31'b0, e.e_trap});
            @(posedge clk); #1;
        end
        drive_idle();

        // Reset asserted mid-DRAIN with the late ack arriving around release
        jump_valid = 1; target_addr = 32'h80;
        @(negedge clk);
        chk("drain entry flush", {31'b0, flush}, 32'h1);
        @(posedge clk); #1;
        drive_idle();
        #1;
        rst_n = 1'b0;
        if_ack = 1'b1;
        #1;
        chk("async reset if_req", {31'b0, if_req}, 32'h0);
        chk("async reset if_addr", if_addr, 32'h0);
        chk("async reset inst_valid", {31'b0, inst_valid}, 32'h0);
        chk("async reset flush", {31'b0, flush}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("boot late ack inst_valid", {31'b0, inst_valid}, 32'h0);
        chk("boot if_req", {31'b0, if_req}, 32'h0);
        @(posedge clk); #1;
        if_ack = 1'b0;
        @(negedge clk);
        chk("post reset if_req", {31'b0, if_req}, 32'h1);
        chk("post reset if_addr", if_addr, 32'h0);
        chk("post reset inst_valid", {31'b0, inst_valid}, 32'h0);
        @(posedge clk); #1;
        if_ack = 1'b1;
        @(negedge clk);
        chk("post reset fetch valid", {31'b0, inst_valid}, 32'h1);
        chk("post reset fetch pc", inst_pc, 32'h0);
        @(posedge clk); #1;
        drive_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_controller.md
PC_CONTROLLER -- requirements
Module: pc_controller

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter TRAP_VEC, default 32'h0000_0100, meaning the redirect target on a misaligned-target trap.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port branch_ctrl, input, 1, the branch-taken decision from the branch controller.
REQ-006 SHALL have port branch_valid, input, 1, meaning execute holds a conditional branch.
REQ-007 SHALL have port jump_valid, input, 1, meaning execute holds JAL/JALR (unconditional).
REQ-008 SHALL have port target_addr, input, 32, the redirect target, sampled when the redirect is taken.
REQ-009 SHALL have port stall, input, 1, which blocks issue of new fetch requests.
REQ-010 SHALL have port if_req, output, 1, the fetch request.
REQ-011 SHALL have port if_addr, output, 32, the fetch address.
REQ-012 SHALL have port if_ack, input, 1, the fetch-complete handshake from instruction memory.
REQ-013 SHALL have port inst_valid, output, 1, meaning a non-stale instruction has been delivered this cycle.
REQ-014 SHALL have port inst_pc, output, 32, the address of the delivered instruction.
REQ-015 SHALL have port flush, output, 1, which kills IF/ID contents.
REQ-016 SHALL have port trap, output, 1, the misaligned-target trap pulse.

Function
REQ-017 SHALL treat redirect = (branch_valid & branch_ctrl) | jump_valid.
REQ-018 SHALL implement FSM states BOOT, FETCH and DRAIN, plus TRAP when MISALIGN_TRAP_EN is defined; reset state is BOOT.
REQ-019 SHALL use BOOT -> FETCH unconditionally, with the first if_req=1 at if_addr=RESET_PC in the cycle after BOOT.
REQ-020 SHALL, once if_req is asserted, hold if_req and if_addr stable until the if_ack cycle.
REQ-021 SHALL, on an if_ack in FETCH without redirect, set inst_valid=1 and inst_pc=if_addr in the same cycle, and set pc <= pc+4 with 32-bit wrap (32'hFFFF_FFFC -> 0).
REQ-022 SHALL, on redirect, pulse flush for exactly 1 cycle and capture target_addr.
REQ-023 SHALL, when redirect occurs with no request outstanding, or with if_ack in the same cycle, set pc <= target, suppress inst_valid for that ack, and issue if_req at the target in the next cycle.
REQ-024 SHALL, when redirect occurs with a request outstanding and no ack, enter DRAIN; the stale ack returns to FETCH with inst_valid=0 and the target request follows next cycle.
REQ-025 SHALL, on a second redirect while in DRAIN, overwrite the captured target (last redirect wins) and pulse flush again.
REQ-026 SHALL, while stall=1, not raise a new if_req; an outstanding request completes normally.
REQ-027 SHALL give redirect priority over stall.

Reset
REQ-028 SHALL, on rst_n=0 at any time including mid-transaction, immediately force if_req=0, if_addr=RESET_PC, inst_valid=0, inst_pc=0, flush=0, trap=0, pc=RESET_PC and state=BOOT.
REQ-029 SHALL discard any in-flight memory response after reset release.

Configuration
REQ-030 SHALL, with MISALIGN_TRAP_EN defined, treat a redirect with target_addr[1:0]!=0 as follows: trap=1 for 1 cycle, flush=1, enter TRAP (draining any outstanding request first), then fetch TRAP_VEC.
REQ-031 SHALL, without MISALIGN_TRAP_EN, force target_addr[1:0] to 2'b00, tie trap=0 and omit the TRAP state.

Structure
REQ-032 SHALL place the FSM state encoding, RESET_PC/TRAP_VEC defaults and the instruction width constant in the shared package core_pkg.
REQ-033 SHALL be a single module with no sub-module; the branch controller stays external and feeds branch_ctrl.

Verification
REQ-034 SHALL verify reset release, always-ack memory: if_addr 0x0, 0x4, 0x8 on consecutive cycles with inst_valid=1 each.
REQ-035 SHALL verify a taken branch (branch_valid=1, branch_ctrl=1, target 0x40) with no outstanding request: flush 1 cycle, next if_addr=0x40.
REQ-036 SHALL verify a redirect to 0x80 while request 0x10 awaits ack (ack 3 cycles later): DRAIN, stale ack gives inst_valid=0, then if_addr=0x80.
REQ-037 SHALL verify that stall=1 for 4 cycles with jump_valid=1 (target 0x200) in cycle 2 produces if_req at 0x200 in cycle 3 despite stall.
REQ-038 SHALL verify, with MISALIGN_TRAP_EN, that target 0x42 gives trap=1 and then if_addr=0x100; without MISALIGN_TRAP_EN, that target 0x42 gives if_addr=0x40 and trap=0.
REQ-039 SHALL verify that rst_n=0 asserted mid-DRAIN gives if_req=0 immediately, and that release gives fetch at RESET_PC with the late ack ignored.
